instr_fetch: RTL and testbench

- Instruction source directly upstream of the lab3 cpu.
- Holds a small loadable program memory and a program counter.
- Presents one 16-bit instruction at a time on `run` and holds it stable until the cpu pulses `done`, then advances.
- Stops on a HALT word or at the end of memory. Counts retired instructions for the testbench and for the board display.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/prog_mem.sv | 34 +++
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the lab3 cpu and its instruction fetch front end:
// instruction geometry, the HALT marker and the fetch sequencer states.
package cpu_pkg;

   localparam int IW_DEFAULT = 16;
   localparam logic [15:0] HALT_WORD = 16'hFFFF;

   // Instruction field positions decoded by the cpu
   localparam int RX_MSB      = 15;
   localparam int RX_LSB      = 13;
   localparam int RY_MSB      = 12;
   localparam int RY_LSB      = 10;
   localparam int ALU_SEL_MSB = 6;
   localparam int ALU_SEL_LSB = 3;
   localparam int MODE_BIT    = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   // Retired-instruction counter step that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/prog_mem.sv
// DEPTH x IW program register file: every word resets to HALT_WORD,
// synchronous write, combinational read. Write gating is done by the caller.
module prog_mem
   import cpu_pkg::*;
#(
   parameter int IW    = IW_DEFAULT,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem_r [DEPTH];

   // Word storage; reset leaves an empty program that halts immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= IW'(HALT_WORD);
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction source for the lab3 cpu: loadable program memory, program
// counter and a fetch/issue handshake that holds each word until done.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter  int IW    = IW_DEFAULT,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          done,
   output logic [IW-1:0] run,
   output logic          run_valid,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic          busy,
   output logic [15:0]   instr_count
);

   fetch_state_t  state_r, state_nxt_s;
   logic [AW-1:0] pc_r, pc_nxt_s;
   logic [IW-1:0] run_r, run_nxt_s;
   logic          run_valid_r, run_valid_nxt_s;
   logic          halted_r, halted_nxt_s;
   logic          busy_r, busy_nxt_s;
   logic [15:0]   count_r, count_nxt_s;
   logic          prog_ok_s;
   logic          mem_we_s;
   logic [IW-1:0] mem_rdata_s;

   // Loading is only allowed while no program is executing
   assign prog_ok_s = (state_r == IDLE) || (state_r == HALTED);
   assign mem_we_s  = prog_we & prog_ok_s;

   prog_mem #(
      .IW    (IW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_prog_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we_s),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc_r),
      .rdata (mem_rdata_s)
   );

   // Next-state and next-output decode for the fetch sequencer
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      run_nxt_s       = run_r;
      run_valid_nxt_s = run_valid_r;
      halted_nxt_s    = halted_r;
      count_nxt_s     = count_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               pc_nxt_s    = AW'(0);
               count_nxt_s = 16'd0;
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: begin
            if (mem_rdata_s == IW'(HALT_WORD)) begin
               halted_nxt_s    = 1'b1;
               run_valid_nxt_s = 1'b0;
               state_nxt_s     = HALTED;
            end else begin
               run_nxt_s       = mem_rdata_s;
               run_valid_nxt_s = 1'b1;
               state_nxt_s     = ISSUE;
            end
         end
         ISSUE: begin
            if (done) begin
               run_valid_nxt_s = 1'b0;
               count_nxt_s     = sat_inc16(count_r);
               // The last word ends the program; pc never wraps to 0
               if (pc_r == AW'(DEPTH - 1)) begin
                  halted_nxt_s = 1'b1;
                  state_nxt_s  = HALTED;
               end else begin
                  pc_nxt_s    = pc_r + AW'(1);
                  state_nxt_s = FETCH;
               end
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         HALTED: begin
            if (start) begin
               halted_nxt_s = 1'b0;
               pc_nxt_s     = AW'(0);
               count_nxt_s  = 16'd0;
               state_nxt_s  = FETCH;
            end else begin
               halted_nxt_s = 1'b1;
               state_nxt_s  = HALTED;
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            run_valid_nxt_s = 1'b0;
            halted_nxt_s    = 1'b0;
         end
      endcase
      busy_nxt_s = (state_nxt_s == FETCH) || (state_nxt_s == ISSUE);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         pc_r        <= AW'(0);
         run_r       <= IW'(0);
         run_valid_r <= 1'b0;
         halted_r    <= 1'b0;
         busy_r      <= 1'b0;
         count_r     <= 16'd0;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         run_r       <= run_nxt_s;
         run_valid_r <= run_valid_nxt_s;
         halted_r    <= halted_nxt_s;
         busy_r      <= busy_nxt_s;
         count_r     <= count_nxt_s;
      end
   end

   assign run         = run_r;
   assign run_valid   = run_valid_r;
   assign pc          = pc_r;
   assign halted      = halted_r;
   assign busy        = busy_r;
   assign instr_count = count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected issue words are queued by the
// stimulus and popped by a monitor on every rising edge of run_valid.
module tb_instr_fetch;

   localparam int IW    = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [IW-1:0] prog_data;
   logic          done;
   logic [IW-1:0] run;
   logic          run_valid;
   logic [AW-1:0] pc;
   logic          halted;
   logic          busy;
   logic [15:0]   instr_count;

   int            vectors = 0;
   int            miscompares = 0;
   logic [IW-1:0] exp_q [$];
   logic [IW-1:0] exp_word;
   logic          rv_prev = 1'b0;

   always #5 clk = ~clk;

   instr_fetch #(.IW(IW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .done        (done),
      .run         (run),
      .run_valid   (run_valid),
      .pc          (pc),
      .halted      (halted),
      .busy        (busy),
      .instr_count (instr_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each new issue must match the oldest queued expectation
   always @(negedge clk) begin
      if (reset && run_valid && !rv_prev) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_issue: got %0h expected no issue at %0t", run, $time);
         end else begin
            exp_word = exp_q.pop_front();
            check("issue_word", 32'(run), 32'(exp_word));
         end
      end
      rv_prev <= reset ? run_valid : 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic ack();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (run_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(run_valid), 32'd1);
   endtask

   task automatic wait_halted(input string name);
      int n = 0;
      while (halted !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(halted), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises;
      int doubles;
      int last_rise;
      logic rv_last;

      reset     = 1'b1;
      start     = 1'b0;
      prog_we   = 1'b0;
      prog_addr = 4'd0;
      prog_data = 16'd0;
      done      = 1'b0;
      #1 reset = 1'b0;
      #2;
      check("rst_run", 32'(run), 32'd0);
      check("rst_run_valid", 32'(run_valid), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Test 1: two instructions then HALT
      load(4'd0, 16'h2408);
      load(4'd1, 16'h4810);
      load(4'd2, 16'hFFFF);
      exp_q.push_back(16'h2408);
      exp_q.push_back(16'h4810);
      pulse_start();
      check("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 2; i++) begin
         wait_valid("t1_valid_timeout");
         tick();
         tick();
         ack();
      end
      wait_halted("t1_halt_timeout");
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_count", 32'(instr_count), 32'd2);

      // Test 2: cpu stalls with done low for 10 cycles
      exp_q.push_back(16'h2408);
      exp_q.push_back(16'h4810);
      pulse_start();
      check("t2_restart_halted", 32'(halted), 32'd0);
      wait_valid("t2_valid_timeout");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t2_hold_run", 32'(run), 32'h2408);
         check("t2_hold_valid", 32'(run_valid), 32'd1);
         check("t2_hold_pc", 32'(pc), 32'd0);
         check("t2_hold_count", 32'(instr_count), 32'd0);
      end
      ack();
      wait_valid("t2_valid2_timeout");
      ack();
      wait_halted("t2_halt_timeout");
      check("t2_count", 32'(instr_count), 32'd2);

      // Test 3: full memory, no wrap
      for (int i = 0; i < DEPTH; i++) begin
         load(AW'(i), 16'h0001);
         exp_q.push_back(16'h0001);
      end
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         wait_valid("t3_valid_timeout");
         ack();
      end
      wait_halted("t3_halt_timeout");
      check("t3_pc", 32'(pc), 32'd15);
      check("t3_count", 32'(instr_count), 32'd16);
      check("t3_busy", 32'(busy), 32'd0);
      repeat (3) tick();
      check("t3_pc_stays", 32'(pc), 32'd15);
      check("t3_halted_stays", 32'(halted), 32'd1);

      // Test 4: writes while busy are dropped
      load(4'd0, 16'hABCD);
      exp_q.push_back(16'hABCD);
      for (int i = 1; i < DEPTH; i++) exp_q.push_back(16'h0001);
      pulse_start();
      wait_valid("t4_valid_timeout");
      load(4'd0, 16'h1234);
      ack();
      load(4'd0, 16'h1234);
      for (int i = 1; i < DEPTH; i++) begin
         wait_valid("t4_valid_timeout");
         ack();
      end
      wait_halted("t4_halt_timeout");
      check("t4_count", 32'(instr_count), 32'd16);
      exp_q.push_back(16'hABCD);
      pulse_start();
      wait_valid("t4_restart_timeout");
      check("t4_restart_count", 32'(instr_count), 32'd0);
      check("t4_restart_pc", 32'(pc), 32'd0);

      // Test 5: asynchronous reset in ISSUE
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("t5_rst_valid", 32'(run_valid), 32'd0);
      check("t5_rst_pc", 32'(pc), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_count", 32'(instr_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();
      pulse_start();
      wait_halted("t5_halt_timeout");
      check("t5_count", 32'(instr_count), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);

      // Test 6: done held high, one retirement every two cycles
      load(4'd0, 16'h1111);
      load(4'd1, 16'h2222);
      load(4'd2, 16'h3333);
      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
      exp_q.push_back(16'h3333);
      done = 1'b1;
      pulse_start();
      rises     = 0;
      doubles   = 0;
      last_rise = 0;
      rv_last   = 1'b0;
      for (int i = 0; i < 40 && halted !== 1'b1; i++) begin
         @(negedge clk);
         if (run_valid && rv_last) doubles++;
         if (run_valid && !rv_last) begin
            if (rises > 0) check("t6_issue_gap", 32'(i - last_rise), 32'd2);
            rises++;
            last_rise = i;
         end
         rv_last = run_valid;
      end
      done = 1'b0;
      check("t6_halted", 32'(halted), 32'd1);
      check("t6_issues", 32'(rises), 32'd3);
      check("t6_back_to_back", 32'(doubles), 32'd0);
      check("t6_count", 32'(instr_count), 32'd3);
      check("t6_pc", 32'(pc), 32'd3);

      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
